// File: rtl/culsans_pkg.sv
// Shared constants and types for the culsans tohost/console device.
package culsans_pkg;

    localparam logic [2:0] TOHOST_OFF   = 3'd0;
    localparam logic [2:0] FROMHOST_OFF = 3'd1;
    localparam logic [2:0] PUTC_OFF     = 3'd2;
    localparam logic [2:0] WDOG_LIM_OFF = 3'd3;
    localparam logic [2:0] STATUS_OFF   = 3'd4;

    typedef enum logic {
        RUN,
        EXITED
    } tohost_state_e;

endpackage

// File: rtl/culsans_char_fifo.sv
// Synchronous character FIFO; head is presented registered, zero when empty.
module culsans_char_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8,
    localparam int PtrWidth = $clog2(Depth),
    localparam int CntWidth = PtrWidth + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [Width-1:0]    wdata,
    input  logic                pop,
    output logic [Width-1:0]    rdata,
    output logic                full,
    output logic                empty,
    output logic [CntWidth-1:0] count
);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = count == CntWidth'(Depth);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/culsans_tohost_ctrl.sv
// End-of-test (TOHOST), console PUTC FIFO and cycle watchdog slave.
module culsans_tohost_ctrl
    import culsans_pkg::*;
#(
    parameter int          AddrWidth   = 64,
    parameter int          DataWidth   = 64,
    parameter int          FifoDepth   = 8,
    parameter logic [31:0] TimeoutCode = 32'h0000_DEAD
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [7:0]             char_o,
    output logic                   char_valid_o,
    input  logic                   char_ready_i,
    output logic [31:0]            exit_o
);

    localparam int NumBytes = DataWidth / 8;
    localparam int CntWidth = $clog2(FifoDepth) + 1;

    tohost_state_e        state;
    tohost_state_e        state_next;
    logic [DataWidth-1:0] tohost;
    logic [DataWidth-1:0] fromhost;
    logic [DataWidth-1:0] wdog_lim;
    logic [DataWidth-1:0] tohost_merged;
    logic [DataWidth-1:0] fromhost_merged;
    logic [DataWidth-1:0] wdog_merged;
    logic [DataWidth-1:0] rd_value;
    logic [31:0]          exit_next;
    logic [31:0]          wdog_cnt;
    logic [31:0]          wdog_max;
    logic [2:0]           off;
    logic                 wr;
    logic                 rd;
    logic                 push;
    logic                 pop;
    logic                 wdog_wr;
    logic                 wdog_on;
    logic                 wdog_expire;
    logic                 sw_exit;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CntWidth-1:0]  fifo_count;
    logic                 unused_addr;

    function automatic logic [DataWidth-1:0] merge(
        input logic [DataWidth-1:0] old,
        input logic [DataWidth-1:0] data,
        input logic [NumBytes-1:0]  be
    );
        logic [DataWidth-1:0] res;
        res = old;
        for (int i = 0; i < NumBytes; i++) begin
            if (be[i]) res[i*8 +: 8] = data[i*8 +: 8];
        end
        return res;
    endfunction

    assign off         = addr_i[5:3];
    assign unused_addr = ^{addr_i[AddrWidth-1:6], addr_i[2:0]};

    // A PUTC write into a full FIFO stalls instead of dropping the byte.
    assign gnt_o = rst && req_i && !(we_i && off == PUTC_OFF && fifo_full);
    assign wr    = gnt_o && we_i;
    assign rd    = gnt_o && !we_i;

    assign tohost_merged   = merge(tohost, wdata_i, be_i);
    assign fromhost_merged = merge(fromhost, wdata_i, be_i);
    assign wdog_merged     = merge(wdog_lim, wdata_i, be_i);

    assign push         = wr && off == PUTC_OFF && be_i[0];
    assign pop          = char_valid_o && char_ready_i;
    assign char_valid_o = !fifo_empty;

    assign wdog_wr     = wr && off == WDOG_LIM_OFF;
    assign wdog_max    = wdog_lim[31:0];
    assign wdog_on     = state == RUN && wdog_max != '0;
    assign wdog_expire = wdog_on && !wdog_wr && wdog_cnt == wdog_max - 32'd1;
    assign sw_exit     = wr && off == TOHOST_OFF && tohost_merged[0];

    always_comb begin
        rd_value = '0;
        case (off)
            TOHOST_OFF:   rd_value = tohost;
            FROMHOST_OFF: rd_value = fromhost;
            WDOG_LIM_OFF: rd_value = wdog_lim;
            STATUS_OFF:   rd_value = DataWidth'({fifo_count, fifo_full,
                                                 fifo_empty, state == EXITED});
            default:      rd_value = '0;
        endcase
    end

    // Software exit code takes priority over a coincident watchdog expiry.
    always_comb begin
        state_next = state;
        exit_next  = exit_o;
        if (state == RUN) begin
            if (sw_exit) begin
                state_next = EXITED;
                exit_next  = tohost_merged[31:0];
            end else if (wdog_expire) begin
                state_next = EXITED;
                exit_next  = {TimeoutCode[30:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            exit_o   <= '0;
            tohost   <= '0;
            fromhost <= '0;
            wdog_lim <= '0;
            wdog_cnt <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            state    <= state_next;
            exit_o   <= exit_next;
            rvalid_o <= gnt_o;
            rdata_o  <= rd ? rd_value : '0;
            if (wr && off == TOHOST_OFF)   tohost   <= tohost_merged;
            if (wr && off == FROMHOST_OFF) fromhost <= fromhost_merged;
            if (wdog_wr) begin
                wdog_lim <= wdog_merged;
                wdog_cnt <= '0;
            end else if (wdog_on) begin
                wdog_cnt <= wdog_cnt + 32'd1;
            end
        end
    end

    culsans_char_fifo #(
        .Depth(FifoDepth),
        .Width(8)
    ) u_fifo (
        .clk  (clk_i),
        .rst  (rst),
        .push (push),
        .wdata(wdata_i[7:0]),
        .pop  (pop),
        .rdata(char_o),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_culsans_tohost_ctrl.sv
// Directed and randomized bench with a queue/array reference model.
module tb_culsans_tohost_ctrl;

    localparam logic [31:0] TIMEOUT = 32'h0000_DEAD;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [7:0]  be_i = '0;
    logic [63:0] wdata_i = '0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic [7:0]  char_o;
    logic        char_valid_o;
    logic        char_ready_i = 1'b0;
    logic [31:0] exit_o;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_reg [8];
    logic [7:0]  m_q [$];
    logic [7:0]  seen [$];
    logic [31:0] m_exit;
    bit          m_exited;
    longint      cyc = 0;
    longint      wd_start = 0;

    always #5 clk_i = ~clk_i;

    culsans_tohost_ctrl dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .char_o      (char_o),
        .char_valid_o(char_valid_o),
        .char_ready_i(char_ready_i),
        .exit_o      (exit_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_q.delete();
        m_exit = '0;
        m_exited = 1'b0;
        wd_start = cyc;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit r, input bit w, input logic [2:0] o,
                        input logic [7:0] b, input logic [63:0] d,
                        input bit rdy);
        logic [63:0] merged;
        logic [63:0] rval;
        logic [63:0] lim;
        bit full;
        bit g;
        bit pop;
        req_i = r;
        we_i = w;
        addr_i = {$urandom(), $urandom()};
        addr_i[5:3] = o;
        be_i = b;
        wdata_i = d;
        char_ready_i = rdy;
        #1;
        full = m_q.size() == 8;
        g = r && !(w && o == 3'd2 && full);
        chk("gnt", 64'(gnt_o), 64'(g));
        pop = m_q.size() != 0 && rdy;
        if (pop) seen.push_back(char_o);
        case (o)
            3'd0, 3'd1, 3'd3: rval = m_reg[o];
            3'd4: rval = {57'd0, 4'(m_q.size()), full, m_q.size() == 0, m_exited};
            default: rval = '0;
        endcase
        merged = m_reg[o];
        for (int i = 0; i < 8; i++)
            if (b[i]) merged[i*8 +: 8] = d[i*8 +: 8];
        lim = m_reg[3];
        cyc++;
        if (!m_exited) begin
            if (g && w && o == 3'd0 && merged[0]) begin
                m_exited = 1'b1;
                m_exit = merged[31:0];
            end else if (lim[31:0] != 0 && !(g && w && o == 3'd3)
                         && cyc - wd_start == longint'(lim[31:0])) begin
                m_exited = 1'b1;
                m_exit = {TIMEOUT[30:0], 1'b1};
            end
        end
        if (pop) void'(m_q.pop_front());
        if (g && w) begin
            if (o == 3'd0 || o == 3'd1 || o == 3'd3) m_reg[o] = merged;
            if (o == 3'd3) wd_start = cyc;
            if (o == 3'd2 && b[0]) m_q.push_back(d[7:0]);
        end
        @(posedge clk_i);
        #1;
        chk("rvalid", 64'(rvalid_o), 64'(g));
        if (g) chk("rdata", rdata_o, w ? 64'd0 : rval);
        chk("exit", 64'(exit_o), 64'(m_exit));
        chk("char_valid", 64'(char_valid_o), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("char", 64'(char_o), 64'(m_q[0]));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_char_valid", 64'(char_valid_o), 64'd0);
        chk("rst_char", 64'(char_o), 64'd0);
        chk("rst_exit", 64'(exit_o), 64'd0);
        req_i = 1'b0;
        we_i = 1'b0;
        char_ready_i = 1'b0;
        @(posedge clk_i);
        #3;
        rst = 1'b1;
        @(posedge clk_i);
        #1;
        cyc++;
        model_reset();
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  b;
        #2;
        do_reset();
        step(1'b1, 1'b0, 3'd4, 8'h00, 64'd0, 1'b0);
        chk("status_reset", rdata_o, 64'h2);

        step(1'b1, 1'b1, 3'd0, 8'hFF, 64'h1, 1'b0);
        chk("exit_first", 64'(exit_o), 64'h1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 64'd0, 1'b0);
        step(1'b1, 1'b1, 3'd0, 8'hFF, 64'h7, 1'b0);
        chk("exit_sticky", 64'(exit_o), 64'h1);
        step(1'b1, 1'b0, 3'd0, 8'h00, 64'd0, 1'b0);

        do_reset();
        step(1'b1, 1'b1, 3'd0, 8'hFF, 64'h6, 1'b0);
        chk("exit_code_bit0_clear", 64'(exit_o), 64'h0);
        step(1'b1, 1'b1, 3'd0, 8'hFF, 64'h7, 1'b0);
        chk("exit_code3", 64'(exit_o), 64'h7);

        do_reset();
        for (int i = 0; i < 120; i++) begin
            d = {$urandom(), $urandom()};
            b = 8'($urandom());
            case ($urandom_range(0, 7))
                0: step(1'b1, 1'b1, 3'd1, b, d, 1'($urandom()));
                1: step(1'b1, 1'b0, 3'd1, b, d, 1'($urandom()));
                2: step(1'b1, 1'b0, 3'd0, b, d, 1'($urandom()));
                3: step(1'b1, 1'b1, 3'd0, b, d & ~64'h1, 1'($urandom()));
                4: step(1'b1, 1'b1, 3'd2, b, d, 1'($urandom()));
                5: step(1'b1, 1'b0, 3'd4, b, d, 1'($urandom()));
                6: step(1'b1, 1'($urandom()), 3'($urandom_range(5, 7)), b, d,
                        1'($urandom()));
                default: step(1'b0, 1'b0, 3'd0, b, d, 1'($urandom()));
            endcase
        end

        do_reset();
        seen.delete();
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 3'd2, 8'h01, 64'(8'h41 + i), 1'b0);
        step(1'b1, 1'b1, 3'd2, 8'h01, 64'h49, 1'b0);
        step(1'b1, 1'b0, 3'd4, 8'h00, 64'd0, 1'b0);
        begin
            bit granted;
            granted = 1'b0;
            for (int k = 0; k < 4 && !granted; k++) begin
                granted = m_q.size() < 8;
                step(1'b1, 1'b1, 3'd2, 8'h01, 64'h49, 1'b1);
            end
        end
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 3'd0, 8'h00, 64'd0, 1'b1);
        chk("order_len", 64'(seen.size()), 64'd9);
        for (int i = 0; i < 9 && i < seen.size(); i++)
            chk("order", 64'(seen[i]), 64'(8'h41 + i));

        do_reset();
        step(1'b1, 1'b1, 3'd3, 8'hFF, 64'd100, 1'b0);
        for (int i = 0; i < 99; i++)
            step(1'b0, 1'b0, 3'd0, 8'h00, 64'd0, 1'b0);
        chk("wdog_before", 64'(exit_o), 64'h0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 64'd0, 1'b0);
        chk("wdog_expire", 64'(exit_o), 64'h0001_BD5B);

        do_reset();
        step(1'b1, 1'b1, 3'd3, 8'hFF, 64'd100, 1'b0);
        for (int i = 0; i < 99; i++)
            step(1'b0, 1'b0, 3'd0, 8'h00, 64'd0, 1'b0);
        step(1'b1, 1'b1, 3'd0, 8'hFF, 64'h3, 1'b0);
        chk("wdog_vs_sw", 64'(exit_o), 64'h3);

        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 3'd2, 8'h01, 64'(8'h61 + i), 1'b0);
        step(1'b1, 1'b1, 3'd0, 8'h0F, 64'h5, 1'b0);
        step(1'b1, 1'b0, 3'd1, 8'h00, 64'd0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 3'd4, 8'h00, 64'd0, 1'b0);
        chk("post_rst_status", rdata_o, 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
